// File: rtl/wb_buffer_sched.sv
// Write-back scheduler for a 16-entry FIFO buffer: round-robin merges two eviction
// requesters into the buffer and drains it to memory over a valid/ready handshake.
module wb_buffer_sched #(
  parameter int DW           = 32,
  parameter int DEPTH        = 16,
  parameter int DRAIN_THRESH = 4
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         req0_valid,
  input  logic [DW-1:0]                req0_data,
  output logic                         req0_ready,
  input  logic                         req1_valid,
  input  logic [DW-1:0]                req1_data,
  output logic                         req1_ready,
  input  logic                         flush,
  output logic                         flush_done,
  output logic                         buf_en,
  output logic                         buf_rd,
  output logic                         buf_wr,
  output logic                         buf_rst,
  output logic [DW-1:0]                buf_din,
  input  logic [DW-1:0]                buf_dout,
  output logic                         mem_valid,
  output logic [DW-1:0]                mem_data,
  input  logic                         mem_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OW = $clog2(DEPTH+1);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD,
    ST_LOAD,
    ST_SEND
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [OW-1:0] occ;
  logic          flush_pend;
  logic          rr_ptr;      // requester preferred when both are valid
  logic          wr_allow;
  logic          grant0;
  logic          grant1;
  logic          wr_fire;
  logic          rd_fire;
  logic          drain_go;

  // Writes are kept out of RD so the buffer never sees RD and WR together.
  always_comb begin
    wr_allow = (state != ST_INIT) && (state != ST_RD) &&
               (occ < OW'(DEPTH)) && !flush_pend;
    grant0   = wr_allow && req0_valid && (!req1_valid || !rr_ptr);
    grant1   = wr_allow && req1_valid && (!req0_valid ||  rr_ptr);
    wr_fire  = grant0 || grant1;
    rd_fire  = (state == ST_RD);
    drain_go = (occ != '0) && ((occ >= OW'(DRAIN_THRESH)) || flush_pend);
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: state_next = ST_IDLE;
      ST_IDLE: if (drain_go) state_next = ST_RD;
      ST_RD:   state_next = ST_LOAD;
      ST_LOAD: state_next = ST_SEND;
      ST_SEND: if (mem_ready) state_next = ST_IDLE;
      default: state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= ST_INIT;
      occ        <= '0;
      flush_pend <= 1'b0;
      rr_ptr     <= 1'b0;
      mem_data   <= '0;
    end else begin
      state <= state_next;
      if (wr_fire)
        occ <= occ + OW'(1);
      else if (rd_fire)
        occ <= occ - OW'(1);
      // Completion wins over a coincident pulse: a pulse while pending is ignored.
      if (flush_done)
        flush_pend <= 1'b0;
      else if (flush)
        flush_pend <= 1'b1;
      if (grant0)
        rr_ptr <= 1'b1;
      else if (grant1)
        rr_ptr <= 1'b0;
      if (state == ST_LOAD)
        mem_data <= buf_dout;
    end
  end

  // buf_rst is held low while Rst is asserted so it pulses only after release.
  assign buf_rst    = (state == ST_INIT) && !Rst;
  assign buf_rd     = rd_fire;
  assign buf_wr     = wr_fire;
  assign buf_en     = buf_rd || buf_wr || buf_rst;
  assign buf_din    = grant0 ? req0_data : (grant1 ? req1_data : '0);
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign mem_valid  = (state == ST_SEND);
  assign flush_done = flush_pend && (occ == '0) && (state == ST_IDLE);
  assign occupancy  = occ;

endmodule

// File: tb/tb_wb_buffer_sched.sv
// Scoreboard bench for wb_buffer_sched: stimulus queues expected grants and memory
// words; a negedge monitor pops and compares whenever the DUT presents a transfer.
module tb_wb_buffer_sched;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        req0_valid = 1'b0;
  logic [31:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [31:0] req1_data = '0;
  logic        req1_ready;
  logic        flush = 1'b0;
  logic        flush_done;
  logic        buf_en, buf_rd, buf_wr, buf_rst;
  logic [31:0] buf_din;
  logic [31:0] buf_dout = '0;
  logic        mem_valid;
  logic [31:0] mem_data;
  logic        mem_ready = 1'b0;
  logic [4:0]  occupancy;

  int n_vec = 0;
  int n_err = 0;
  int cyc_cnt = 0;

  logic        exp_grant[$];
  logic [31:0] exp_mem[$];
  int          hs_q[$];
  logic [31:0] fifo_model[$];   // stands in for the physical buffer
  logic        mon_g;

  wb_buffer_sched #(.DW(32), .DEPTH(16), .DRAIN_THRESH(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .flush(flush), .flush_done(flush_done),
    .buf_en(buf_en), .buf_rd(buf_rd), .buf_wr(buf_wr), .buf_rst(buf_rst),
    .buf_din(buf_din), .buf_dout(buf_dout),
    .mem_valid(mem_valid), .mem_data(mem_data), .mem_ready(mem_ready),
    .occupancy(occupancy)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc_cnt <= cyc_cnt + 1;

  // Behavioural buffer: buf_rst clears, WR pushes, RD presents the head next cycle.
  always @(posedge Clk) begin
    if (buf_en && buf_rst) fifo_model.delete();
    else if (buf_en && buf_wr) fifo_model.push_back(buf_din);
    else if (buf_en && buf_rd && fifo_model.size() > 0) buf_dout <= fifo_model.pop_front();
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    check("en_rdwr", {30'd0, buf_en, buf_rd & buf_wr}, {30'd0, buf_rd | buf_wr | buf_rst, 1'b0});
    if (req0_ready || req1_ready) begin
      if (exp_grant.size() == 0)
        check("unexpected_grant", {30'd0, req1_ready, req0_ready}, 32'd0);
      else begin
        mon_g = exp_grant.pop_front();
        check("grant_id", {30'd0, req1_ready, req0_ready}, mon_g ? 32'd2 : 32'd1);
        check("buf_din", buf_din, mon_g ? req1_data : req0_data);
      end
    end
    if (mem_valid && mem_ready) begin
      hs_q.push_back(cyc_cnt);
      if (exp_mem.size() == 0)
        check("unexpected_mem", {30'd0, mem_valid, mem_ready}, 32'd0);
      else
        check("mem_data", mem_data, exp_mem.pop_front());
    end
  end

  // Holds each requester valid until it has delivered n words of base+index.
  task automatic drive_writes(input int n0, input int n1, input logic [31:0] b0,
                              input logic [31:0] b1, input int budget);
    int c0 = 0, c1 = 0, k = 0;
    logic g0, g1;
    req0_valid = (n0 > 0); req0_data = b0;
    req1_valid = (n1 > 0); req1_data = b1;
    while ((c0 < n0 || c1 < n1) && k < budget) begin
      @(negedge Clk); g0 = req0_ready; g1 = req1_ready;
      @(posedge Clk); #1;
      if (g0) c0++;
      if (g1) c1++;
      req0_valid = (c0 < n0); req0_data = b0 + 32'(c0);
      req1_valid = (c1 < n1); req1_data = b1 + 32'(c1);
      k++;
    end
    check("wr_done0", 32'(c0), 32'(n0));
    check("wr_done1", 32'(c1), 32'(n1));
  endtask

  task automatic flush_and_wait(input int budget, input bit poke);
    bit seen = 0;
    int k = 0, extra = 0;
    flush = 1'b1;
    @(posedge Clk); #1;
    flush = 1'b0;
    if (poke) begin req1_valid = 1'b1; req1_data = 32'hF00D_0001; end
    while (!seen && k < budget) begin
      @(negedge Clk);
      if (flush_done) begin
        seen = 1;
        check("flush_occ", 32'(occupancy), 32'd0);
      end
      k++;
    end
    @(posedge Clk); #1;
    req1_valid = 1'b0;
    repeat (5) begin
      @(negedge Clk);
      if (flush_done) extra++;
    end
    @(posedge Clk); #1;
    check("flush_done_seen", 32'(seen), 32'd1);
    check("flush_extra", 32'(extra), 32'd0);
    check("mem_q_empty", 32'(exp_mem.size()), 32'd0);
    check("grant_q_empty", 32'(exp_grant.size()), 32'd0);
  endtask

  initial begin
    #2 Rst = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_outs", {26'd0, mem_valid, buf_rst, buf_en, flush_done, req0_ready, req1_ready}, 32'd0);
    check("rst_mem_data", mem_data, 32'd0);
    @(posedge Clk); #1 Rst = 1'b0;
    @(negedge Clk);
    check("init_rst", {30'd0, buf_rst, buf_en}, 32'd3);
    @(negedge Clk);
    check("idle_outs", {29'd0, buf_rst, buf_en, mem_valid}, 32'd0);
    @(posedge Clk); #1;

    // Both requesters continuously valid: grants alternate, words drain in order.
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
      exp_mem.push_back(32'hA000_0000 + 32'(i)); exp_mem.push_back(32'hB000_0000 + 32'(i));
    end
    drive_writes(4, 4, 32'hA000_0000, 32'hB000_0000, 200);
    flush_and_wait(100, 1'b0);

    // Fill to DEPTH with memory stalled; one extra word sits in SEND.
    mem_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      exp_grant.push_back(1'b0); exp_mem.push_back(32'hC000_0000 + 32'(i));
    end
    drive_writes(17, 0, 32'hC000_0000, 32'd0, 300);
    check("full_occ", 32'(occupancy), 32'd16);
    req0_valid = 1'b1; req0_data = 32'hC000_0011;
    repeat (3) begin
      @(negedge Clk);
      check("full_block", {31'd0, req0_ready}, 32'd0);
    end
    @(posedge Clk); #1;
    hs_q.delete();
    mem_ready = 1'b1;
    begin
      bit acc = 0;
      logic g;
      for (int k = 0; k < 50 && !acc; k++) begin
        @(negedge Clk); g = req0_ready;
        @(posedge Clk); #1;
        if (g) acc = 1;
      end
      check("full_release", 32'(acc), 32'd1);
    end
    req0_valid = 1'b0;
    for (int k = 0; k < 200 && hs_q.size() < 15; k++) begin
      @(posedge Clk); #1;
    end
    repeat (8) @(posedge Clk);
    #1;
    check("drain_count", 32'(hs_q.size()), 32'd15);
    check("residual_occ", 32'(occupancy), 32'd3);
    for (int i = 1; i < hs_q.size(); i++)
      check("drain_gap", 32'(hs_q[i] - hs_q[i-1]), 32'd4);

    // Flush the three residual words while requester 1 tries to write.
    flush_and_wait(100, 1'b1);

    // Flush on an empty buffer completes one cycle after the pulse.
    flush = 1'b1;
    @(negedge Clk);
    check("flush_empty_early", {31'd0, flush_done}, 32'd0);
    @(posedge Clk); #1 flush = 1'b0;
    @(negedge Clk);
    check("flush_empty_done", {31'd0, flush_done}, 32'd1);
    @(negedge Clk);
    check("flush_empty_once", {31'd0, flush_done}, 32'd0);
    @(posedge Clk); #1;

    // SEND stalled five cycles, accepted on the sixth.
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_grant.push_back(1'b0); exp_mem.push_back(32'hD000_0000 + 32'(i));
    end
    drive_writes(4, 0, 32'hD000_0000, 32'd0, 100);
    begin
      bit found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
        @(negedge Clk);
        if (mem_valid) found = 1;
      end
      check("send_reached", 32'(found), 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge Clk);
      check("stall_valid", {31'd0, mem_valid}, 32'd1);
      check("stall_data", mem_data, 32'hD000_0000);
    end
    @(posedge Clk); #1 mem_ready = 1'b1;
    @(negedge Clk);
    check("accept_valid", {31'd0, mem_valid}, 32'd1);
    @(negedge Clk);
    check("after_accept", {31'd0, mem_valid}, 32'd0);
    @(posedge Clk); #1;
    flush_and_wait(100, 1'b0);

    // Reset in LOAD with occupancy 5.
    mem_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      exp_grant.push_back(1'b0); exp_mem.push_back(32'hE000_0000 + 32'(i));
    end
    drive_writes(7, 0, 32'hE000_0000, 32'd0, 100);
    check("pre_occ", 32'(occupancy), 32'd6);
    mem_ready = 1'b1;
    @(posedge Clk); #1 mem_ready = 1'b0;
    begin
      bit rd_seen = 0;
      for (int k = 0; k < 20 && !rd_seen; k++) begin
        @(negedge Clk);
        if (buf_rd) rd_seen = 1;
      end
      check("rd_seen", 32'(rd_seen), 32'd1);
    end
    @(posedge Clk); #1;
    check("load_occ", 32'(occupancy), 32'd5);
    Rst = 1'b1;
    #1;
    check("async_occ", 32'(occupancy), 32'd0);
    check("async_outs", {29'd0, mem_valid, buf_en, buf_rst}, 32'd0);
    exp_mem.delete(); exp_grant.delete();
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    check("reinit_rst", {30'd0, buf_rst, buf_en}, 32'd3);
    @(negedge Clk);
    check("reinit_done", {27'd0, buf_rst, mem_valid, occupancy == 5'd0, buf_en, buf_wr}, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
